// File: rtl/sc1_pkg.sv
// Shared types and sizing for the simple_circuit1 go/no-go checker.
package sc1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_e;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;
    localparam int unsigned ERR_W       = 4;
    localparam int unsigned SETTLE_W    = 4;

endpackage

// File: rtl/sc1_golden.sv
// Reference model of the circuit under test: D = (A & B) | !C, E = !C.
module sc1_golden (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d_exp,
    output logic e_exp
);

    assign d_exp = (a & b) | ~c;
    assign e_exp = ~c;

endmodule

// File: rtl/simple_circuit1_checker.sv
// Walks all 8 {A,B,C} vectors through the external circuit, compares D/E against
// the golden model and reports error count plus the first failing vector.
module simple_circuit1_checker
    import sc1_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             d_in,
    input  logic             e_in,
    output logic             a_out,
    output logic             b_out,
    output logic             c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] fail_vec
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0]    VEC_LAST    = VEC_W'(NUM_VECTORS - 1);

    state_e              state_q, state_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0]    fail_vec_q, fail_vec_d;
    logic                pass_q, pass_d;
    logic                d_exp, e_exp;
    logic                mismatch;

    sc1_golden u_golden (
        .a     (vec_q[2]),
        .b     (vec_q[1]),
        .c     (vec_q[0]),
        .d_exp (d_exp),
        .e_exp (e_exp)
    );

    assign mismatch = (d_in != d_exp) || (e_in != e_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            settle_q     <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            pass_q       <= pass_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        pass_d       = pass_q;

        // Abort outranks everything, including a start seen in the same cycle.
        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            vec_d    = '0;
            settle_d = '0;
            pass_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d      = DRIVE;
                        vec_d        = '0;
                        settle_d     = '0;
                        err_d        = '0;
                        fail_valid_d = 1'b0;
                        fail_vec_d   = '0;
                        pass_d       = 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = CHECK;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_vec_d   = vec_q;
                        end
                    end
                    // pass is taken from err_d so the final vector's result is included.
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = DRIVE;
                        vec_d   = vec_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy                  = (state_q == DRIVE) || (state_q == CHECK);
        done                  = (state_q == DONE);
        {a_out, b_out, c_out} = busy ? vec_q : '0;
        pass                  = pass_q;
        err_count             = err_q;
        fail_valid            = fail_valid_q;
        fail_vec              = fail_vec_q;
    end

endmodule

// File: tb/tb_simple_circuit1_checker.sv
// Directed bench: two checker instances (SETTLE_CYCLES 1 and 3) against a faultable circuit model.
module tb_simple_circuit1_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic       start0, start3;
    int         mode0, mode3;
    logic       d0, e0, a0, b0, c0, busy0, done0, pass0, fv0;
    logic       d3, e3, a3, b3, c3, busy3, done3, pass3, fv3;
    logic [3:0] err0, err3;
    logic [2:0] fvec0, fvec3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // mode 0: correct, 1: D stuck at 0, 2: E inverted, 3: D = (A|B)|!C
    function automatic logic [1:0] cut(input int mode, input logic a, input logic b, input logic c);
        logic d_ok, e_ok;
        d_ok = (a & b) | ~c;
        e_ok = ~c;
        case (mode)
            1:       return {1'b0, e_ok};
            2:       return {d_ok, ~e_ok};
            3:       return {(a | b) | ~c, e_ok};
            default: return {d_ok, e_ok};
        endcase
    endfunction

    always_comb {d0, e0} = cut(mode0, a0, b0, c0);
    always_comb {d3, e3} = cut(mode3, a3, b3, c3);

    simple_circuit1_checker #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
        .d_in(d0), .e_in(e0), .a_out(a0), .b_out(b0), .c_out(c0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .fail_vec(fvec0)
    );

    simple_circuit1_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort),
        .d_in(d3), .e_in(e3), .a_out(a3), .b_out(b3), .c_out(c3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .fail_vec(fvec3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic get(input int sel, output logic busy, output logic done, output logic pass,
                       output logic fv, output logic [3:0] err, output logic [2:0] fvec,
                       output logic [2:0] abc);
        if (sel == 0) begin
            busy = busy0; done = done0; pass = pass0; fv = fv0; err = err0; fvec = fvec0;
            abc = {a0, b0, c0};
        end else begin
            busy = busy3; done = done3; pass = pass3; fv = fv3; err = err3; fvec = fvec3;
            abc = {a3, b3, c3};
        end
    endtask

    typedef struct {
        string      name;
        int         sel;
        int         mode;
        int         err;
        logic       fv;
        logic [2:0] fvec;
        logic       pass;
        int         lat;
    } run_t;

    task automatic run_and_check(input run_t r);
        logic bz, dn, ps, fv;
        logic [3:0] er;
        logic [2:0] fvc, abc;
        int n;
        if (r.sel == 0) mode0 = r.mode; else mode3 = r.mode;
        @(negedge clk);
        if (r.sel == 0) start0 = 1'b1; else start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        start3 = 1'b0;
        get(r.sel, bz, dn, ps, fv, er, fvc, abc);
        chk({r.name, "_busy_t0"}, 32'(bz), 1);
        chk({r.name, "_err_cleared"}, 32'(er), 0);
        chk({r.name, "_fv_cleared"}, 32'(fv), 0);
        n = 0;
        while (!dn && n < 200) begin
            @(posedge clk);
            n++;
            #1 get(r.sel, bz, dn, ps, fv, er, fvc, abc);
        end
        chk({r.name, "_done_latency"}, 32'(n), 32'(r.lat));
        chk({r.name, "_err_count"}, 32'(er), 32'(r.err));
        chk({r.name, "_fail_valid"}, 32'(fv), 32'(r.fv));
        chk({r.name, "_fail_vec"}, 32'(fvc), 32'(r.fvec));
        chk({r.name, "_pass"}, 32'(ps), 32'(r.pass));
        chk({r.name, "_busy_at_done"}, 32'(bz), 0);
        @(posedge clk);
        #1 get(r.sel, bz, dn, ps, fv, er, fvc, abc);
        chk({r.name, "_done_one_cycle"}, 32'(dn), 0);
        chk({r.name, "_pass_hold"}, 32'(ps), 32'(r.pass));
    endtask

    task automatic count_done(input int cycles, output int dn);
        dn = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1 if (done0) dn++;
        end
    endtask

    run_t tbl[6];

    initial begin
        int dn, dn_at, bz17, bz18;

        tbl[0] = '{"clean",      0, 0, 0, 1'b0, 3'b000, 1'b1, 16};
        tbl[1] = '{"d_stuck0",   0, 1, 5, 1'b1, 3'b000, 1'b0, 16};
        tbl[2] = '{"e_inv",      0, 2, 8, 1'b1, 3'b000, 1'b0, 16};
        tbl[3] = '{"d_or",       0, 3, 2, 1'b1, 3'b011, 1'b0, 16};
        tbl[4] = '{"d_or_s3",    1, 3, 2, 1'b1, 3'b011, 1'b0, 32};
        tbl[5] = '{"clean_s3",   1, 0, 0, 1'b0, 3'b000, 1'b1, 32};

        rst_n = 1'b0; abort = 1'b0; start0 = 1'b0; start3 = 1'b0;
        mode0 = 0; mode3 = 0;
        #2;
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_abc", 32'({a0, b0, c0}), 0);
        chk("rst_done_pass", 32'({done0, pass0, fv0}), 0);
        chk("rst_err_fvec", 32'({err0, fvec0}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_and_check(tbl[i]);

        // abort during vector 3 with E inverted: vectors 0..2 already counted
        mode0 = 2;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk);
        @(negedge clk); start0 = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_vec3_driven", 32'({a0, b0, c0}), 3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_abc", 32'({a0, b0, c0}), 0);
        chk("abort_pass", 32'(pass0), 0);
        chk("abort_err_kept", 32'(err0), 3);
        chk("abort_fv_kept", 32'(fv0), 1);
        chk("abort_fvec_kept", 32'(fvec0), 0);
        @(negedge clk); abort = 1'b0;
        count_done(20, dn);
        chk("abort_no_done", 32'(dn), 0);
        chk("abort_err_hold", 32'(err0), 3);

        // abort and start together in IDLE: nothing starts
        @(negedge clk); start0 = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 chk("abort_beats_start", 32'(busy0), 0);
        @(negedge clk); start0 = 1'b0; abort = 1'b0;

        run_and_check('{"restart", 0, 0, 0, 1'b0, 3'b000, 1'b1, 16});

        // asynchronous reset mid-run
        mode0 = 2;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk);
        @(negedge clk); start0 = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_abc", 32'({a0, b0, c0}), 0);
        chk("midrst_err", 32'(err0), 0);
        chk("midrst_fail", 32'({fv0, fvec0}), 0);
        @(negedge clk); rst_n = 1'b1;
        count_done(20, dn);
        chk("midrst_no_done", 32'(dn), 0);

        // start held high: one done at +16, next run begins at +18
        mode0 = 0;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk);
        dn = 0; dn_at = 0; bz17 = -1; bz18 = -1;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk);
            #1;
            if (done0) begin dn++; dn_at = n; end
            if (n == 17) bz17 = int'(busy0);
            if (n == 18) bz18 = int'(busy0);
        end
        chk("held_done_count", 32'(dn), 1);
        chk("held_done_edge", 32'(dn_at), 16);
        chk("held_idle_gap", 32'(bz17), 0);
        chk("held_restart", 32'(bz18), 1);
        @(negedge clk); start0 = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        #1 chk("held_aborted", 32'(busy0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
